fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 152 +++++++++++++++
 tb/tb_fetch_stage.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage with a single outstanding request to instruction
// memory, a one-entry instruction buffer, and kill tracking so that a redirect
// arriving while a fetch is in flight discards that fetch's data.
//
// state | meaning
// ------+---------------------------------------------------------------
// REQ   | fetch request to PC outstanding, waiting for imem_ack
// HOLD  | IBUF holds a live instruction for PC, no request outstanding
// KILL  | request to PC still outstanding, but its data is to be dropped;
//       | once acked, fetching restarts at TGT
module fetch_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  StallF,
  input  logic                  PCSrcE,
  input  logic [DATA_WIDTH-1:0] PCTargetE,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] RDi,
  output logic [DATA_WIDTH-1:0] PCF,
  output logic [DATA_WIDTH-1:0] PC_PlusF,
  output logic                  ValidF
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_HOLD = 2'd1,
    ST_KILL = 2'd2
  } state_t;

  localparam logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~(DATA_WIDTH'(3));

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] tgt_q, tgt_d;
  logic [DATA_WIDTH-1:0] ibuf_q, ibuf_d;

  logic [DATA_WIDTH-1:0] redirect_pc;
  logic [DATA_WIDTH-1:0] pc_plus4;

  // Redirect targets are always word aligned; the low bits are simply dropped.
  assign redirect_pc = PCTargetE & ALIGN_MASK;
  // Sequential successor wraps naturally at the top of the address space.
  assign pc_plus4    = pc_q + PC_STEP;

  // State register; reset abandons any outstanding transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: PC, pending redirect target, instruction buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      tgt_q  <= RESET_PC;
      ibuf_q <= NOP_INSTR;
    end else begin
      pc_q   <= pc_d;
      tgt_q  <= tgt_d;
      ibuf_q <= ibuf_d;
    end
  end

  // Next-state decision: redirect has priority over stall in every state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_REQ: begin
        if (imem_ack) begin
          state_d = PCSrcE ? ST_REQ : ST_HOLD;
        end else if (PCSrcE) begin
          state_d = ST_KILL;
        end
      end
      ST_HOLD: begin
        if (PCSrcE || !StallF) begin
          state_d = ST_REQ;
        end
      end
      ST_KILL: begin
        if (imem_ack) begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase
  end

  // Next values for PC / TGT / IBUF, following the same state decode.
  always_comb begin
    pc_d   = pc_q;
    tgt_d  = tgt_q;
    ibuf_d = ibuf_q;
    case (state_q)
      ST_REQ: begin
        if (imem_ack) begin
          if (PCSrcE) begin
            pc_d = redirect_pc;
          end else begin
            ibuf_d = imem_rdata;
          end
        end else if (PCSrcE) begin
          // Address must stay stable until ack, so park the target.
          tgt_d = redirect_pc;
        end
      end
      ST_HOLD: begin
        if (PCSrcE) begin
          pc_d = redirect_pc;
        end else if (!StallF) begin
          pc_d = pc_plus4;
        end
      end
      ST_KILL: begin
        if (PCSrcE) begin
          // The most recent redirect wins over an older parked target.
          tgt_d = redirect_pc;
          if (imem_ack) begin
            pc_d = redirect_pc;
          end
        end else if (imem_ack) begin
          pc_d = tgt_q;
        end
      end
      default: begin
        pc_d = pc_q;
      end
    endcase
  end

  // Output decode; imem_req drops combinationally with rst.
  always_comb begin
    imem_req  = (state_q != ST_HOLD) && !rst;
    imem_addr = pc_q;
    PCF       = pc_q;
    PC_PlusF  = pc_plus4;
    RDi       = ibuf_q;
    ValidF    = (state_q == ST_HOLD);
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a latency-programmable instruction memory
// model, a scoreboard of expected consumed instructions checked by a monitor,
// and directed checks on handshake, redirect and reset behaviour.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallF;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] RDi;
  logic [31:0] PCF;
  logic [31:0] PC_PlusF;
  logic        ValidF;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] plus;
    logic [31:0] rdi;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   lat      = 0;

  fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .StallF     (StallF),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .RDi        (RDi),
    .PCF        (PCF),
    .PC_PlusF   (PC_PlusF),
    .ValidF     (ValidF)
  );

  always #5 clk = ~clk;

  // Memory model: acks after lat wait cycles at a stable address; word = {C0DE, addr[15:0]}.
  logic        prev_req  = 1'b0;
  logic        prev_ack  = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  int          wcnt      = 0;
  always @(negedge clk) begin
    #1;
    if (rst) wcnt = 0;
    else if (imem_req && prev_req && !prev_ack && imem_addr == prev_addr) wcnt = wcnt + 1;
    else wcnt = 0;
    imem_ack   = imem_req && (wcnt >= lat);
    imem_rdata = {16'hC0DE, imem_addr[15:0]};
    prev_req   = imem_req;
    prev_ack   = imem_ack;
    prev_addr  = imem_addr;
  end

  // Monitor: every consumed instruction must match the head of the scoreboard.
  always @(negedge clk) begin
    #3;
    if (!rst && ValidF && !StallF && !PCSrcE) begin
      n_checks = n_checks + 1;
      if (exp_q.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL consume_unexpected: got pc=%h rdi=%h, required none", PCF, RDi);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (PCF !== e.pc || PC_PlusF !== e.plus || RDi !== e.rdi) begin
          n_fail = n_fail + 1;
          $display("FAIL consume: got pc=%h plus=%h rdi=%h, required pc=%h plus=%h rdi=%h",
                   PCF, PC_PlusF, RDi, e.pc, e.plus, e.rdi);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks = n_checks + 1;
    if (act !== req) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] plus, input logic [31:0] rdi);
    exp_t e;
    e.pc = pc; e.plus = plus; e.rdi = rdi;
    exp_q.push_back(e);
  endtask

  task automatic wait_hold(input logic [31:0] pc, input string name);
    bit found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!found) begin
        tick();
        found = ValidF && (PCF == pc);
      end
    end
    if (!found) begin
      n_checks = n_checks + 1;
      n_fail   = n_fail + 1;
      $display("FAIL %s: timeout, PCF=%h, required HOLD at %h", name, PCF, pc);
    end
  endtask

  task automatic wait_req(input logic [31:0] addr, input string name);
    bit found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!found) begin
        tick();
        found = imem_req && !ValidF && (imem_addr == addr);
      end
    end
    if (!found) begin
      n_checks = n_checks + 1;
      n_fail   = n_fail + 1;
      $display("FAIL %s: timeout, imem_addr=%h, required request at %h", name, imem_addr, addr);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [5:0] valid_pat;
  bit         acked;

  initial begin
    rst = 1'b1; StallF = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
    #1;
    chk("rst_validf",   {31'h0, ValidF},   32'h0);
    chk("rst_imem_req", {31'h0, imem_req}, 32'h0);
    chk("rst_rdi",      RDi,               32'h0000_0013);
    chk("rst_pcf",      PCF,               32'h0);

    // Zero-wait memory: 0, 4, 8 fetched; 8 then stalled.
    push(32'h0, 32'h4, 32'hC0DE_0000);
    push(32'h4, 32'h8, 32'hC0DE_0004);
    push(32'h8, 32'hC, 32'hC0DE_0008);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("first_req",  {31'h0, imem_req}, 32'h1);
    chk("first_addr", imem_addr,         32'h0);
    valid_pat[0] = ValidF;
    for (int i = 1; i < 6; i++) begin
      tick();
      valid_pat[i] = ValidF;
    end
    chk("valid_pattern", {26'h0, valid_pat}, 32'h0000_002A);
    chk("hold_pc8", PCF, 32'h8);
    StallF = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", {31'h0, ValidF}, 32'h1);
      chk("stall_pcf",   PCF,             32'h8);
      chk("stall_rdi",   RDi,             32'hC0DE_0008);
    end
    StallF = 1'b0;
    lat = 3;
    push(32'hC, 32'h10, 32'hC0DE_000C);
    tick();
    chk("after_stall_addr", imem_addr, 32'hC);

    // 3-cycle latency, redirect while fetch to 0x10 is in flight.
    wait_req(32'h10, "wait_req_10");
    tick();
    chk("kill_addr_stable", imem_addr, 32'h10);
    PCSrcE = 1'b1; PCTargetE = 32'h100;
    acked = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!acked) begin
        tick();
        PCSrcE = 1'b0;
        chk("kill_addr_wait", imem_addr,         32'h10);
        chk("kill_no_valid",  {31'h0, ValidF},   32'h0);
        acked = imem_ack;
      end
    end
    if (!acked) chk("kill_ack_timeout", 32'h0, 32'h1);
    tick();
    chk("redirect_addr_100", imem_addr,       32'h100);
    chk("redirect_valid",    {31'h0, ValidF}, 32'h0);
    lat = 0;

    // Stall then redirect in HOLD to an unaligned target.
    wait_hold(32'h100, "wait_hold_100");
    StallF = 1'b1;
    tick();
    chk("hold100_stalled", PCF, 32'h100);
    PCSrcE = 1'b1; PCTargetE = 32'h203;
    tick();
    chk("hold_redir_valid", {31'h0, ValidF},   32'h0);
    chk("hold_redir_addr",  imem_addr,         32'h200);
    chk("hold_redir_req",   {31'h0, imem_req}, 32'h1);
    StallF = 1'b0; PCSrcE = 1'b0;
    push(32'h200, 32'h204, 32'hC0DE_0200);

    // Redirect coincident with ack in REQ, to the top word of the address space.
    wait_req(32'h204, "wait_req_204");
    PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFE;
    push(32'hFFFF_FFFC, 32'h0, 32'hC0DE_FFFC);
    push(32'h0, 32'h4, 32'hC0DE_0000);
    tick();
    PCSrcE = 1'b0;
    chk("ack_redir_addr",  imem_addr,       32'hFFFF_FFFC);
    chk("ack_redir_valid", {31'h0, ValidF}, 32'h0);
    wait_hold(32'hFFFF_FFFC, "wait_hold_top");
    tick();
    chk("wrap_addr", imem_addr, 32'h0);
    wait_hold(32'h0, "wait_hold_0");
    lat = 3;

    // Enter KILL with pending target 0x40, then reset.
    wait_req(32'h4, "wait_req_4");
    PCSrcE = 1'b1; PCTargetE = 32'h40;
    tick();
    PCSrcE = 1'b0;
    chk("kill4_addr",  imem_addr,       32'h4);
    chk("kill4_valid", {31'h0, ValidF}, 32'h0);
    rst = 1'b1;
    #1;
    chk("midrst_validf",   {31'h0, ValidF},   32'h0);
    chk("midrst_rdi",      RDi,               32'h0000_0013);
    chk("midrst_pcf",      PCF,               32'h0);
    chk("midrst_imem_req", {31'h0, imem_req}, 32'h0);
    tick(); tick();
    lat = 0;
    push(32'h0, 32'h4, 32'hC0DE_0000);
    rst = 1'b0;
    tick();
    chk("postrst_addr", imem_addr,         32'h0);
    chk("postrst_req",  {31'h0, imem_req}, 32'h1);
    wait_hold(32'h0, "wait_hold_postrst");
    tick();
    rst = 1'b1;
    tick(); tick();
    chk("queue_drained", exp_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
